// File: rtl/note_player_pkg.sv
// Shared music package: widths, amplitudes and FSM encodings for the voice players.
package note_player_pkg;

  localparam int NOTE_WIDTH     = 6;
  localparam int DURATION_WIDTH = 6;
  localparam int PHASE_WIDTH    = 22;
  localparam int STEP_WIDTH     = 20;
  localparam int SAMPLE_WIDTH   = 16;
  localparam int SQUARE_AMPL    = 8192;

  // IDLE must stay at zero so the flop library's reset value lands in IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/dffar.sv
// Flop library, async active-low reset variant of dffr: clears to zero on reset_n low.
module dffar #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= d;
  end

endmodule

// File: rtl/note_freq_table.sv
// Note index to phase step for a 22-bit accumulator at 48 kHz; note 49 is A4 (440 Hz), 0 is a rest.
module note_freq_table
  import note_player_pkg::*;
(
  input  logic [NOTE_WIDTH-1:0] note,
  output logic [STEP_WIDTH-1:0] step
);

  always_comb begin
    step = '0;
    case (note)
      6'd0:  step = 20'd0;
      6'd1:  step = 20'd2403;
      6'd2:  step = 20'd2546;
      6'd3:  step = 20'd2697;
      6'd4:  step = 20'd2858;
      6'd5:  step = 20'd3028;
      6'd6:  step = 20'd3208;
      6'd7:  step = 20'd3398;
      6'd8:  step = 20'd3600;
      6'd9:  step = 20'd3814;
      6'd10: step = 20'd4041;
      6'd11: step = 20'd4282;
      6'd12: step = 20'd4536;
      6'd13: step = 20'd4806;
      6'd14: step = 20'd5092;
      6'd15: step = 20'd5394;
      6'd16: step = 20'd5715;
      6'd17: step = 20'd6055;
      6'd18: step = 20'd6415;
      6'd19: step = 20'd6797;
      6'd20: step = 20'd7201;
      6'd21: step = 20'd7629;
      6'd22: step = 20'd8083;
      6'd23: step = 20'd8563;
      6'd24: step = 20'd9072;
      6'd25: step = 20'd9612;
      6'd26: step = 20'd10183;
      6'd27: step = 20'd10789;
      6'd28: step = 20'd11431;
      6'd29: step = 20'd12110;
      6'd30: step = 20'd12830;
      6'd31: step = 20'd13593;
      6'd32: step = 20'd14402;
      6'd33: step = 20'd15258;
      6'd34: step = 20'd16165;
      6'd35: step = 20'd17126;
      6'd36: step = 20'd18145;
      6'd37: step = 20'd19224;
      6'd38: step = 20'd20367;
      6'd39: step = 20'd21578;
      6'd40: step = 20'd22861;
      6'd41: step = 20'd24220;
      6'd42: step = 20'd25661;
      6'd43: step = 20'd27187;
      6'd44: step = 20'd28803;
      6'd45: step = 20'd30516;
      6'd46: step = 20'd32330;
      6'd47: step = 20'd34253;
      6'd48: step = 20'd36290;
      6'd49: step = 20'd38448;
      6'd50: step = 20'd40734;
      6'd51: step = 20'd43156;
      6'd52: step = 20'd45722;
      6'd53: step = 20'd48441;
      6'd54: step = 20'd51321;
      6'd55: step = 20'd54373;
      6'd56: step = 20'd57606;
      6'd57: step = 20'd61032;
      6'd58: step = 20'd64661;
      6'd59: step = 20'd68506;
      6'd60: step = 20'd72579;
      6'd61: step = 20'd76895;
      6'd62: step = 20'd81468;
      6'd63: step = 20'd86312;
      default: step = '0;
    endcase
  end

endmodule

// File: rtl/note_player.sv
// Single voice: times a note in beats and produces one sample per codec request.
// NOTE_PLAYER_TRIANGLE_EN selects a triangle wave instead of the default square wave.
//
// state   | meaning
// IDLE    | no note, sample_out held at 0
// PLAYING | note sounding, counting down remaining beats
// DONE    | one-cycle completion, done_with_note high
module note_player
  import note_player_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           play_enable,
  input  logic                           load_new_note,
  input  logic [NOTE_WIDTH-1:0]          note_to_load,
  input  logic [DURATION_WIDTH-1:0]      duration_to_load,
  input  logic                           beat,
  input  logic                           generate_next_sample,
  output logic                           done_with_note,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           sample_ready
);

  state_t                         state, next_state;
  logic [1:0]                     state_bits;
  logic [NOTE_WIDTH-1:0]          note, note_next;
  logic [DURATION_WIDTH-1:0]      count, count_next;
  logic [PHASE_WIDTH-1:0]         phase, phase_next;
  logic [STEP_WIDTH-1:0]          step;
  logic signed [SAMPLE_WIDTH-1:0] wave_value, sample_next;
  logic                           done_next, ready_next;

  assign state = state_t'(state_bits);

  dffar #(.WIDTH(2))              u_state_reg  (.clk, .reset_n, .d(next_state),  .q(state_bits));
  dffar #(.WIDTH(NOTE_WIDTH))     u_note_reg   (.clk, .reset_n, .d(note_next),   .q(note));
  dffar #(.WIDTH(DURATION_WIDTH)) u_count_reg  (.clk, .reset_n, .d(count_next),  .q(count));
  dffar #(.WIDTH(PHASE_WIDTH))    u_phase_reg  (.clk, .reset_n, .d(phase_next),  .q(phase));
  dffar #(.WIDTH(SAMPLE_WIDTH))   u_sample_reg (.clk, .reset_n, .d(sample_next), .q(sample_out));
  dffar #(.WIDTH(1))              u_done_reg   (.clk, .reset_n, .d(done_next),   .q(done_with_note));
  dffar #(.WIDTH(1))              u_ready_reg  (.clk, .reset_n, .d(ready_next),  .q(sample_ready));

  note_freq_table u_freq (.note(note), .step(step));

  // The sample reflects the phase at the moment of the request; the accumulator advances alongside.
`ifdef NOTE_PLAYER_TRIANGLE_EN
  logic [14:0] ramp;
  assign ramp = phase[PHASE_WIDTH-1] ? ~phase[PHASE_WIDTH-2:PHASE_WIDTH-16]
                                     :  phase[PHASE_WIDTH-2:PHASE_WIDTH-16];
  assign wave_value = $signed({1'b0, ramp}) - 16'sd16384;
`else
  assign wave_value = phase[PHASE_WIDTH-1] ? -SAMPLE_WIDTH'(SQUARE_AMPL) : SAMPLE_WIDTH'(SQUARE_AMPL);
`endif

  always_comb begin
    next_state  = state;
    note_next   = note;
    count_next  = count;
    phase_next  = phase;
    sample_next = sample_out;
    done_next   = 1'b0;
    ready_next  = play_enable & generate_next_sample;

    if (load_new_note) begin
      next_state = PLAYING;
      note_next  = note_to_load;
      count_next = duration_to_load;
      phase_next = '0;
    end else if (play_enable) begin
      case (state)
        PLAYING: begin
          if (count == '0) begin
            next_state = DONE;
            done_next  = 1'b1;
          end else if (beat) begin
            count_next = count - DURATION_WIDTH'(1);
          end
          if (generate_next_sample)
            phase_next = phase + {{(PHASE_WIDTH-STEP_WIDTH){1'b0}}, step};
        end
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end

    if (play_enable) begin
      if (state != PLAYING)
        sample_next = '0;
      else if (generate_next_sample)
        sample_next = (note == '0) ? '0 : wave_value;
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: vector table for note timing, scoreboard for samples.
module tb_note_player;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               play_enable = 1'b1;
  logic               load_new_note = 1'b0;
  logic [5:0]         note_to_load = '0;
  logic [5:0]         duration_to_load = '0;
  logic               beat = 1'b0;
  logic               generate_next_sample = 1'b0;
  logic               done_with_note;
  logic signed [15:0] sample_out;
  logic               sample_ready;

  localparam logic [21:0] STEP_A4 = 22'd38448;

  int   n_checks = 0;
  int   n_errors = 0;
  int   done_pulses = 0;
  int   exp_done = 0;
  int   exp_q[$];
  logic exp_ready = 1'b0;
  logic [21:0] m_phase;
  int   frozen;

  typedef struct {
    logic [5:0] note;
    logic [5:0] dur;
    int         gap;
  } vec_t;
  vec_t vecs[5];

  note_player dut (
    .clk(clk), .reset_n(reset_n), .play_enable(play_enable),
    .load_new_note(load_new_note), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .beat(beat),
    .generate_next_sample(generate_next_sample), .done_with_note(done_with_note),
    .sample_out(sample_out), .sample_ready(sample_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wave(input logic [21:0] ph);
`ifdef NOTE_PLAYER_TRIANGLE_EN
    logic [14:0] r;
    r = ph[21] ? ~ph[20:6] : ph[20:6];
    return int'(r) - 16384;
`else
    return ph[21] ? -8192 : 8192;
`endif
  endfunction

  // Expected sample_ready: one cycle after an enabled request.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) exp_ready <= 1'b0;
    else          exp_ready <= generate_next_sample && play_enable;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (done_with_note) done_pulses <= done_pulses + 1;
      if (sample_ready || exp_ready) begin
        check("sample_ready", int'(sample_ready), int'(exp_ready));
        if (sample_ready) begin
          check("sb_has_entry", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("sample_out", int'(sample_out), exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] n, input logic [5:0] d, input logic with_beat);
    load_new_note = 1'b1;
    note_to_load = n;
    duration_to_load = d;
    beat = with_beat;
    tick();
    load_new_note = 1'b0;
    beat = 1'b0;
    m_phase = '0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic request(input int exp);
    generate_next_sample = 1'b1;
    exp_q.push_back(exp);
    tick();
    generate_next_sample = 1'b0;
  endtask

  task automatic play_samples(input int n, input logic [21:0] stp, input logic rest);
    for (int k = 0; k < n; k++) begin
      request(rest ? 0 : wave(m_phase));
      m_phase = m_phase + stp;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{6'd49, 6'd4, 2};
    vecs[1] = '{6'd12, 6'd1, 0};
    vecs[2] = '{6'd63, 6'd3, 1};
    vecs[3] = '{6'd0,  6'd2, 3};
    vecs[4] = '{6'd5,  6'd0, 0};

    #12;
    check("reset_done", int'(done_with_note), 0);
    check("reset_sample", int'(sample_out), 0);
    check("reset_ready", int'(sample_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Note timing: done exactly one cycle after the counter reaches zero.
    foreach (vecs[v]) begin
      load(vecs[v].note, vecs[v].dur, 1'b0);
      check("done_after_load", int'(done_with_note), 0);
      for (int b = 0; b < int'(vecs[v].dur); b++) begin
        repeat (vecs[v].gap) begin
          tick();
          check("done_early_gap", int'(done_with_note), 0);
        end
        pulse_beat();
        check("done_early_beat", int'(done_with_note), 0);
      end
      tick();
      check("done_pulse", int'(done_with_note), 1);
      exp_done++;
      tick();
      check("done_single", int'(done_with_note), 0);
      request(0);
    end

    // Rest: timed but silent.
    load(6'd0, 6'd2, 1'b0);
    play_samples(4, 22'd0, 1'b1);
    pulse_beat();
    play_samples(2, 22'd0, 1'b1);
    pulse_beat();
    check("rest_done_early", int'(done_with_note), 0);
    tick();
    check("rest_done", int'(done_with_note), 1);
    exp_done++;
    tick();

    // Waveform across the half-period, then reload coincident with the final beat.
    load(6'd49, 6'd1, 1'b0);
    play_samples(60, STEP_A4, 1'b0);
    load(6'd49, 6'd2, 1'b1);
    check("coincident_no_done", int'(done_with_note), 0);
    tick();
    check("coincident_no_done2", int'(done_with_note), 0);
    play_samples(1, STEP_A4, 1'b0);
    pulse_beat();
    pulse_beat();
    check("reload_done_early", int'(done_with_note), 0);
    tick();
    check("reload_done", int'(done_with_note), 1);
    exp_done++;
    tick();

    // Freeze: ten beats and requests while disabled change nothing.
    load(6'd49, 6'd3, 1'b0);
    play_samples(1, STEP_A4, 1'b0);
    frozen = wave(22'd0);
    pulse_beat();
    play_enable = 1'b0;
    beat = 1'b1;
    generate_next_sample = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("frozen_done", int'(done_with_note), 0);
      check("frozen_sample", int'(sample_out), frozen);
    end
    beat = 1'b0;
    generate_next_sample = 1'b0;
    play_enable = 1'b1;
    pulse_beat();
    check("resume_done_early1", int'(done_with_note), 0);
    pulse_beat();
    check("resume_done_early2", int'(done_with_note), 0);
    tick();
    check("resume_done", int'(done_with_note), 1);
    exp_done++;
    tick();

    // Asynchronous reset mid-note.
    load(6'd49, 6'd3, 1'b0);
    play_samples(1, STEP_A4, 1'b0);
    pulse_beat();
    tick();
    check("pre_reset_sample", int'(sample_out), wave(22'd0));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_done", int'(done_with_note), 0);
    check("async_sample", int'(sample_out), 0);
    check("async_ready", int'(sample_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse_beat();
      check("post_reset_no_done", int'(done_with_note), 0);
    end
    request(0);
    tick();
    tick();

    check("sb_drained", exp_q.size(), 0);
    check("done_pulses", done_pulses, exp_done);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state on rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port play_enable, input, 1 bit: 0 freezes all playback state.
REQ-004 SHALL have port load_new_note, input, 1 bit: 1-cycle strobe from song_reader (new_note_one/two/three).
REQ-005 SHALL have port note_to_load, input, 6 bits: note index, 0 = rest, 1..63 = pitch.
REQ-006 SHALL have port duration_to_load, input, 6 bits: note length in beats.
REQ-007 SHALL have port beat, input, 1 bit: 1-cycle beat tick.
REQ-008 SHALL have port generate_next_sample, input, 1 bit: 1-cycle codec sample request.
REQ-009 SHALL have port done_with_note, output, 1 bit: 1-cycle pulse to song_reader (note_*_done).
REQ-010 SHALL have port sample_out, output, 16 bits signed: current voice sample.
REQ-011 SHALL have port sample_ready, output, 1 bit: 1-cycle pulse when sample_out is updated.

Function
REQ-012 SHALL implement an FSM with states IDLE, PLAYING and DONE.
REQ-013 SHALL, on load_new_note in any state, latch note, latch duration into a 6-bit remaining-beat counter, clear the 22-bit phase accumulator, and enter PLAYING next cycle.
REQ-014 SHALL, in PLAYING with play_enable=1 and beat=1, decrement the remaining-beat counter by 1.
REQ-015 SHALL go PLAYING->DONE on the cycle the counter reaches 0, assert done_with_note for exactly the one DONE cycle, then go DONE->IDLE.
REQ-016 SHALL treat duration_to_load=0 as complete immediately: PLAYING lasts one cycle, then DONE.
REQ-017 SHALL, when load_new_note and the final beat occur in the same cycle, let the load win: no done pulse, new note starts.
REQ-018 SHALL, while play_enable=0, hold the counter, phase, FSM state and sample_out, ignore beat and generate_next_sample, and still honour load_new_note.
REQ-019 SHALL, in PLAYING with play_enable=1 and generate_next_sample=1, add the 20-bit step from the frequency table, zero-extended, to the phase modulo 2^22.
REQ-020 SHALL update sample_out and pulse sample_ready exactly one cycle after that request.
REQ-021 SHALL, in the default waveform, output sample_out=+8192 when phase[21]=0 and -8192 otherwise.
REQ-022 SHALL force step=0 and sample_out=0 for a rest (note 0), while still timing the duration.
REQ-023 SHALL, in IDLE or DONE, drive sample_out=0 and still pulse sample_ready one cycle after generate_next_sample.

Reset
REQ-024 SHALL, on reset_n=0, immediately set state=IDLE, counter=0, phase=0, note=0, done_with_note=0, sample_out=0 and sample_ready=0.
REQ-025 SHALL, on reset mid-note, abandon the note and emit no done pulse.

Configuration
REQ-026 SHALL, with NOTE_PLAYER_TRIANGLE_EN defined, replace the square wave with a triangle wave: sample_out = ((phase[21] ? ~phase[20:6] : phase[20:6]) - 16384), signed, range -16384..+16383.
REQ-027 SHALL, without NOTE_PLAYER_TRIANGLE_EN, use the square wave of REQ-021, with no triangle logic present.

Structure
REQ-028 SHALL take NOTE_WIDTH=6, DURATION_WIDTH=6, PHASE_WIDTH=22, STEP_WIDTH=20, SQUARE_AMPL=8192 and the state encodings from the shared music package.
REQ-029 SHALL place the note-to-step lookup in combinational sub-module note_freq_table, 6-bit in, 20-bit out, with entry 0 = 0.
REQ-030 SHALL build all registers from the existing dffr-style flop library, extended with an async active-low variant.

Verification
REQ-031 SHALL verify: load note 49, duration 4, four beats -> done_with_note single pulse on the cycle after the counter hits 0, state IDLE.
REQ-032 SHALL verify: load duration 0 -> done_with_note pulses 2 cycles after the load, with no beat needed.
REQ-033 SHALL verify: note 0, duration 2, samples requested -> every sample_out=0, sample_ready follows each request by 1 cycle, done after 2 beats.
REQ-034 SHALL verify: play_enable=0 for 10 beats mid-note -> counter unchanged, no done; re-enable -> completes after the remaining beats.
REQ-035 SHALL verify: load_new_note coincident with final beat -> no done pulse, new duration loaded, phase=0.
REQ-036 SHALL verify: reset_n asserted mid-note -> all outputs 0 asynchronously, no done pulse after release; repeat with NOTE_PLAYER_TRIANGLE_EN, checking phase 0 gives -16384.
